// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache control path: arbitration modes, width helpers
// and the channel-slice accessor for flattened per-channel buses.
`define CH_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package cache_ctrl_pkg;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Channel-id width; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/cache_rr_arbiter.sv
// Combinational N-way arbiter: round-robin search starting at ptr, or fixed
// priority (lowest index) when mode selects it. Emits one-hot grant plus index.
module cache_rr_arbiter
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx
);

    int              start;
    int              c;
    logic [CH_W-1:0] ci;
    logic            found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = 0;
        ci      = '0;
        start   = (mode == ARB_FIXED) ? 0 : int'(ptr);
        // NUM_CH need not be a power of two, so wrap with an explicit compare.
        for (int k = 0; k < NUM_CH; k++) begin
            c = start + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            ci = CH_W'(c);
            if (!found && req[ci]) begin
                found   = 1'b1;
                gnt[ci] = 1'b1;
                gnt_idx = ci;
            end
        end
    end

endmodule

// File: rtl/cache_arb_merge_rr.sv
// N-channel merge: one hold slot per producer, one registered output slot,
// round-robin or fixed-priority selection, source channel reported with each word.
module cache_arb_merge_rr
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 6,
    parameter int ARB_MODE   = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            i_drive,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_free,
    output logic                         o_driveNext,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [ch_w(NUM_CH)-1:0]      o_chId,
    input  logic                         i_freeNext
);

    localparam int   CH_W = ch_w(NUM_CH);
    localparam logic MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    logic [NUM_CH-1:0]                 full;
    logic [NUM_CH-1:0]                 accept;
    logic [NUM_CH-1:0]                 gnt;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] slot_data;
    logic [CH_W-1:0]                   rr_ptr;
    logic [CH_W-1:0]                   gnt_idx;
    logic                              out_ready;
    logic                              do_grant;

    // Ready comes straight from slot state, so no path from i_freeNext to o_free.
    assign o_free    = ~full;
    assign accept    = i_drive & ~full;
    assign out_ready = ~o_driveNext | i_freeNext;
    assign do_grant  = out_ready & (|full);

    cache_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req     (full),
        .ptr     (rr_ptr),
        .mode    (MODE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full      <= '0;
            slot_data <= '0;
        end else begin
            full <= (full & ~(gnt & {NUM_CH{do_grant}})) | accept;
            for (int i = 0; i < NUM_CH; i++)
                if (accept[i]) slot_data[i] <= `CH_SLICE(i_data, i, DATA_WIDTH);
        end
    end

    // Drain and reload happen on the same edge, giving back-to-back words.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_driveNext <= 1'b0;
            o_data      <= '0;
            o_chId      <= '0;
            rr_ptr      <= '0;
        end else if (out_ready) begin
            o_driveNext <= do_grant;
            if (do_grant) begin
                o_data <= slot_data[gnt_idx];
                o_chId <= gnt_idx;
                rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_arb_merge_rr.sv
// Directed and random bench for cache_arb_merge_rr: 4-ch RR, 4-ch fixed priority,
// and a 3-ch 16-bit RR soak, all scoreboarded per channel.
module tb_cache_arb_merge_rr;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [3:0]  a_drive, a_free;
    logic [23:0] a_data;
    logic        a_vld, a_rdy;
    logic [5:0]  a_dout;
    logic [1:0]  a_ch;

    logic [3:0]  f_drive, f_free;
    logic [23:0] f_data;
    logic        f_vld, f_rdy;
    logic [5:0]  f_dout;
    logic [1:0]  f_ch;

    logic [2:0]  s_drive, s_free;
    logic [47:0] s_data;
    logic        s_vld, s_rdy;
    logic [15:0] s_dout;
    logic [1:0]  s_ch;

    cache_arb_merge_rr #(.NUM_CH(4), .DATA_WIDTH(6), .ARB_MODE(0)) u_a (
        .clk(clk), .rstn(rstn), .i_drive(a_drive), .i_data(a_data), .o_free(a_free),
        .o_driveNext(a_vld), .o_data(a_dout), .o_chId(a_ch), .i_freeNext(a_rdy));

    cache_arb_merge_rr #(.NUM_CH(4), .DATA_WIDTH(6), .ARB_MODE(1)) u_f (
        .clk(clk), .rstn(rstn), .i_drive(f_drive), .i_data(f_data), .o_free(f_free),
        .o_driveNext(f_vld), .o_data(f_dout), .o_chId(f_ch), .i_freeNext(f_rdy));

    cache_arb_merge_rr #(.NUM_CH(3), .DATA_WIDTH(16), .ARB_MODE(0)) u_s (
        .clk(clk), .rstn(rstn), .i_drive(s_drive), .i_data(s_data), .o_free(s_free),
        .o_driveNext(s_vld), .o_data(s_dout), .o_chId(s_ch), .i_freeNext(s_rdy));

    logic [15:0] qa[4][$];
    logic [15:0] qf[4][$];
    logic [15:0] qs[3][$];
    int          s_wait[3];
    int          f_cnt[4];
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: push accepted words, advance, then score any newly loaded output word.
    task automatic tick();
        logic        pa_v, pa_r, pf_v, pf_r, ps_v, ps_r;
        logic [3:0]  pf_free;
        logic [2:0]  ps_free;
        logic [15:0] e;
        int          lo;
        int          g;
        pa_v = a_vld; pa_r = a_rdy;
        pf_v = f_vld; pf_r = f_rdy; pf_free = f_free;
        ps_v = s_vld; ps_r = s_rdy; ps_free = s_free;
        for (int i = 0; i < 4; i++) begin
            if (a_drive[i] && a_free[i]) qa[i].push_back(16'(a_data[i*6 +: 6]));
            if (f_drive[i] && f_free[i]) qf[i].push_back(16'(f_data[i*6 +: 6]));
        end
        for (int i = 0; i < 3; i++)
            if (s_drive[i] && s_free[i]) qs[i].push_back(s_data[i*16 +: 16]);
        @(posedge clk);
        #1;
        if (a_vld && (!pa_v || pa_r)) begin
            chk("a_expected", 32'(qa[a_ch].size() > 0), 32'd1);
            if (qa[a_ch].size() > 0) begin
                e = qa[a_ch].pop_front();
                chk("a_data", 32'(a_dout), 32'(e));
            end
        end
        if (f_vld && (!pf_v || pf_r)) begin
            lo = 4;
            for (int i = 3; i >= 0; i--) if (!pf_free[i]) lo = i;
            chk("f_prio", 32'(f_ch), 32'(lo));
            f_cnt[f_ch]++;
            chk("f_expected", 32'(qf[f_ch].size() > 0), 32'd1);
            if (qf[f_ch].size() > 0) begin
                e = qf[f_ch].pop_front();
                chk("f_data", 32'(f_dout), 32'(e));
            end
        end
        if (s_vld && (!ps_v || ps_r)) begin
            g = int'(s_ch);
            chk("s_chrange", 32'(g < 3), 32'd1);
            if (g < 3) begin
                chk("s_fair", 32'(s_wait[g] <= 2), 32'd1);
                s_wait[g] = 0;
                for (int j = 0; j < 3; j++) if (j != g && !ps_free[j]) s_wait[j]++;
                chk("s_expected", 32'(qs[g].size() > 0), 32'd1);
                if (qs[g].size() > 0) begin
                    e = qs[g].pop_front();
                    chk("s_data", 32'(s_dout), 32'(e));
                end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        for (int i = 0; i < 3; i++) s_wait[i] = 0;
        for (int i = 0; i < 4; i++) f_cnt[i] = 0;
        rstn = 1'b0;
        a_drive = '0; a_data = '0; a_rdy = 1'b0;
        f_drive = '0; f_data = '0; f_rdy = 1'b0;
        s_drive = '0; s_data = '0; s_rdy = 1'b0;
        #12;
        chk("rst_free", 32'(a_free), 32'hF);
        chk("rst_vld", 32'(a_vld), 32'd0);
        chk("rst_data", 32'(a_dout), 32'd0);
        chk("rst_ch", 32'(a_ch), 32'd0);
        chk("rst_s_free", 32'(s_free), 32'h7);
        rstn = 1'b1;
        tick();

        // Reset in the middle of a burst: three slots full plus a word in the output slot.
        a_rdy = 1'b0;
        a_drive = 4'hF;
        a_data = {6'h0D, 6'h0C, 6'h0B, 6'h0A};
        tick();
        a_drive = '0;
        chk("burst_full", 32'(a_free), 32'h0);
        tick();
        chk("burst_vld", 32'(a_vld), 32'd1);
        chk("burst_ch0", 32'(a_ch), 32'd0);
        chk("burst_3full", 32'(a_free), 32'h1);
        rstn = 1'b0;
        #1;
        chk("rst_mid_free", 32'(a_free), 32'hF);
        chk("rst_mid_vld", 32'(a_vld), 32'd0);
        for (int i = 0; i < 4; i++) qa[i].delete();
        tick();
        chk("rst_hold_vld", 32'(a_vld), 32'd0);
        rstn = 1'b1;
        a_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_stale", 32'(a_vld), 32'd0);
        end

        // Round-robin over all four slots, then a partial refill.
        a_drive = 4'hF;
        a_data = {6'h13, 6'h12, 6'h11, 6'h10};
        tick();
        a_drive = '0;
        chk("rr_fill_vld", 32'(a_vld), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_vld", 32'(a_vld), 32'd1);
            chk("rr_ch", 32'(a_ch), 32'(k));
            chk("rr_data", 32'(a_dout), 32'(6'h10 + k));
        end
        a_drive = 4'b1001;
        a_data = {6'h23, 6'h00, 6'h00, 6'h20};
        tick();
        a_drive = '0;
        chk("rr_drain_vld", 32'(a_vld), 32'd0);
        tick();
        chk("rr2_ch0", 32'(a_ch), 32'd0);
        chk("rr2_d0", 32'(a_dout), 32'h20);
        tick();
        chk("rr2_ch3", 32'(a_ch), 32'd3);
        chk("rr2_d3", 32'(a_dout), 32'h23);
        tick();
        chk("rr2_idle", 32'(a_vld), 32'd0);

        // Backpressure: output must hold and the pending slot must stay full.
        a_rdy = 1'b0;
        a_drive = 4'b0110;
        a_data = {6'h00, 6'h32, 6'h31, 6'h00};
        tick();
        a_drive = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_vld", 32'(a_vld), 32'd1);
            chk("bp_data", 32'(a_dout), 32'h31);
            chk("bp_ch", 32'(a_ch), 32'd1);
            chk("bp_free", 32'(a_free), 32'hB);
        end
        a_rdy = 1'b1;
        tick();
        chk("bp_rel_vld", 32'(a_vld), 32'd1);
        chk("bp_rel_ch", 32'(a_ch), 32'd2);
        chk("bp_rel_data", 32'(a_dout), 32'h32);
        chk("bp_rel_free", 32'(a_free), 32'hF);
        tick();
        chk("drain_vld", 32'(a_vld), 32'd0);
        chk("drain_keep_data", 32'(a_dout), 32'h32);
        chk("drain_keep_ch", 32'(a_ch), 32'd2);

        // Single word on ch2.
        a_drive = 4'b0100;
        a_data = {6'h00, 6'h15, 6'h00, 6'h00};
        tick();
        a_drive = '0;
        chk("single_free", 32'(a_free), 32'hB);
        chk("single_vld0", 32'(a_vld), 32'd0);
        tick();
        chk("single_vld", 32'(a_vld), 32'd1);
        chk("single_data", 32'(a_dout), 32'h15);
        chk("single_ch", 32'(a_ch), 32'd2);
        chk("single_free2", 32'(a_free), 32'hF);
        tick();
        chk("single_end", 32'(a_vld), 32'd0);

        // Fixed priority: ch1 and ch3 driven continuously.
        f_rdy = 1'b1;
        f_drive = 4'b1010;
        for (int n = 0; n < 36; n++) begin
            f_data = {6'(32 + n), 6'h00, 6'(n), 6'h00};
            if (n >= 16) f_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        f_drive = '0;
        f_rdy = 1'b1;
        repeat (6) tick();
        chk("f_ch3_served", 32'(f_cnt[3] > 0), 32'd1);
        chk("f_ch1_ge_ch3", 32'(f_cnt[1] >= f_cnt[3]), 32'd1);

        // Random soak on the 3-channel, 16-bit instance.
        for (int n = 0; n < 800; n++) begin
            s_drive = 3'($urandom_range(0, 7));
            s_data = {16'($urandom), 16'($urandom), 16'($urandom)};
            s_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        s_drive = '0;
        s_rdy = 1'b1;
        repeat (10) tick();

        for (int i = 0; i < 4; i++) begin
            chk("a_leftover", 32'(qa[i].size()), 32'd0);
            chk("f_leftover", 32'(qf[i].size()), 32'd0);
        end
        for (int i = 0; i < 3; i++) chk("s_leftover", 32'(qs[i].size()), 32'd0);
        chk("s_idle", 32'(s_vld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
